// File: rtl/p_shfrot_mc_if.sv
// Request/response bundle for the multi-cycle packed shift/rotate unit.
// The issue pipeline is the master; the shifter is the slave.
interface p_shfrot_mc_if;
  logic        valid;
  logic        kill;
  logic [31:0] crs1;
  logic [4:0]  shamt;
  logic [4:0]  pw;
  logic        shift;
  logic        rotate;
  logic        left;
  logic        right;
  logic        ready;
  logic        done;
  logic [31:0] result;

  modport master (
    output valid, kill, crs1, shamt, pw, shift, rotate, left, right,
    input  ready, done, result
  );

  modport slave (
    input  valid, kill, crs1, shamt, pw, shift, rotate, left, right,
    output ready, done, result
  );
endinterface

// File: rtl/p_shfrot_mc.sv
// Multi-cycle packed shift/rotate: every lane moves one bit per cycle,
// so a k-position operation takes k RUN cycles followed by one DONE cycle.
module p_shfrot_mc (
  input  logic            clock,
  input  logic            reset,
  p_shfrot_mc_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] PW_32 = 5'b00001;
  localparam logic [4:0] PW_16 = 5'b00010;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b01000;
  localparam logic [4:0] PW_2  = 5'b10000;

  state_e      state_q;
  logic [31:0] data_q;
  logic [5:0]  cnt_q;
  logic [4:0]  pw_q;
  logic        rot_q;
  logic        left_q;
  logic        ready_q;
  logic        done_q;

  logic        op_ok;
  logic        pw_ok;
  logic        rot_sel;
  logic [5:0]  lane_w;
  logic [5:0]  k_d;
  logic [31:0] step_d;

  // One-bit move of every lane of width w; nothing crosses a lane boundary.
  function automatic logic [31:0] lane_step(input logic [31:0] d, input int w,
                                            input logic rot, input logic lft);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b += w) begin
      for (int j = 0; j < w; j++) begin
        if (lft) begin
          if (j == 0) r[b] = rot & d[b + w - 1];
          else        r[b + j] = d[b + j - 1];
        end else begin
          if (j == w - 1) r[b + j] = rot & d[b];
          else            r[b + j] = d[b + j + 1];
        end
      end
    end
    return r;
  endfunction

  // Request decode: shift wins over rotate, left wins over right.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    op_ok   = (bus.shift | bus.rotate) & (bus.left | bus.right);
    pw_ok   = $onehot(bus.pw);
    rot_sel = ~bus.shift & bus.rotate;
    lane_w  = 6'd0;
    k_d     = 6'd0;
    unique case (bus.pw)
      PW_32:   lane_w = 6'd32;
      PW_16:   lane_w = 6'd16;
      PW_8:    lane_w = 6'd8;
      PW_4:    lane_w = 6'd4;
      PW_2:    lane_w = 6'd2;
      default: lane_w = 6'd0;
    endcase
    if (op_ok && pw_ok) begin
      if (rot_sel) k_d = {1'b0, bus.shamt} & (lane_w - 6'd1);
      else         k_d = ({1'b0, bus.shamt} >= lane_w) ? lane_w : {1'b0, bus.shamt};
    end
  end

  always_comb begin
    step_d = data_q;
    unique case (pw_q)
      PW_32:   step_d = lane_step(data_q, 32, rot_q, left_q);
      PW_16:   step_d = lane_step(data_q, 16, rot_q, left_q);
      PW_8:    step_d = lane_step(data_q, 8,  rot_q, left_q);
      PW_4:    step_d = lane_step(data_q, 4,  rot_q, left_q);
      PW_2:    step_d = lane_step(data_q, 2,  rot_q, left_q);
      default: step_d = data_q;
    endcase
  end

  // ready/done are registered alongside the state so they never glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: state and datapath registers are all cleared here; the result must read 0 out of reset.
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      pw_q    <= PW_32;
      rot_q   <= 1'b0;
      left_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (bus.kill) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.valid) begin
            data_q  <= (op_ok && pw_ok) ? bus.crs1 : 32'd0;
            pw_q    <= bus.pw;
            rot_q   <= rot_sel;
            left_q  <= bus.left;
            cnt_q   <= k_d;
            ready_q <= 1'b0;
            if (k_d == 6'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          data_q <= step_d;
          cnt_q  <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = data_q;

endmodule

// File: tb/tb_p_shfrot_mc.sv
// Directed bench for p_shfrot_mc: cycle-exact handshake and hand-computed results.
module tb_p_shfrot_mc;

  localparam logic [4:0] W32 = 5'b00001;
  localparam logic [4:0] W16 = 5'b00010;
  localparam logic [4:0] W8  = 5'b00100;
  localparam logic [4:0] W4  = 5'b01000;
  localparam logic [4:0] W2  = 5'b10000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  p_shfrot_mc_if bus ();

  p_shfrot_mc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] crs, input logic [4:0] sh, input logic [4:0] pw,
                       input logic s, input logic r, input logic l, input logic rt);
    bus.crs1   = crs;
    bus.shamt  = sh;
    bus.pw     = pw;
    bus.shift  = s;
    bus.rotate = r;
    bus.left   = l;
    bus.right  = rt;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) check("wait_ready_timeout", bus.ready, 1);
  endtask

  // Accept lands on the edge ending cycle 0; returns positioned in cycle 1.
  task automatic start_op(input logic [31:0] crs, input logic [4:0] sh, input logic [4:0] pw,
                          input logic s, input logic r, input logic l, input logic rt);
    wait_ready();
    drive(crs, sh, pw, s, r, l, rt);
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] crs, input logic [4:0] sh,
                        input logic [4:0] pw, input logic s, input logic r, input logic l,
                        input logic rt, input int k, input logic [31:0] exp);
    start_op(crs, sh, pw, s, r, l, rt);
    for (int c = 1; c <= k + 1; c++) begin
      if (c > 1) tick();
      check({tag, "_ready_low"}, bus.ready, 0);
      check({tag, "_done"}, bus.done, (c == k + 1) ? 1 : 0);
    end
    check({tag, "_result"}, bus.result, exp);
    tick();
    check({tag, "_ready_back"}, bus.ready, 1);
    check({tag, "_done_single"}, bus.done, 0);
    check({tag, "_result_held"}, bus.result, exp);
  endtask

  initial begin
    int dones;
    bus.valid = 1'b0;
    bus.kill  = 1'b0;
    drive(32'd0, 5'd0, W32, 1'b0, 1'b0, 1'b0, 1'b0);

    #12;
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    reset = 1'b1;
    tick();

    run_op("rotl32_4",   32'h12345678, 5'd4,  W32, 0, 1, 1, 0, 4,  32'h23456781);
    run_op("shr8_12",    32'hFF807F01, 5'd12, W8,  1, 0, 0, 1, 8,  32'h00000000);
    run_op("rotr16_17",  32'h00018000, 5'd17, W16, 0, 1, 0, 1, 1,  32'h80004000);
    run_op("shl2_0",     32'hDEADBEEF, 5'd0,  W2,  1, 0, 1, 0, 0,  32'hDEADBEEF);
    run_op("multihot",   32'hDEADBEEF, 5'd5,  5'h03, 1, 0, 1, 0, 0, 32'h00000000);
    run_op("no_op",      32'hDEADBEEF, 5'd5,  W32, 0, 0, 1, 0, 0,  32'h00000000);
    run_op("no_dir",     32'hDEADBEEF, 5'd5,  W32, 1, 0, 0, 0, 0,  32'h00000000);
    run_op("rotr2_3",    32'hDEADBEEF, 5'd3,  W2,  0, 1, 0, 1, 1,  32'hED5E7DDF);
    run_op("rotl8_9",    32'h80402010, 5'd9,  W8,  0, 1, 1, 0, 1,  32'h01804020);
    run_op("shl16_16",   32'hFFFFFFFF, 5'd16, W16, 1, 0, 1, 0, 16, 32'h00000000);
    run_op("shr32_31",   32'h80000000, 5'd31, W32, 1, 0, 0, 1, 31, 32'h00000001);
    run_op("prio_shift", 32'h000000F1, 5'd1,  W8,  1, 1, 1, 1, 1,  32'h000000E2);

    // Back-to-back: valid held high; crs1 changes mid-run must not leak in.
    wait_ready();
    drive(32'h00000001, 5'd3, W4, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.valid = 1'b1;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) bus.crs1 = 32'h00000002;
      if (c == 6) bus.valid = 1'b0;
      dones += int'(bus.done);
      if (c == 4) begin
        check("b2b_done1", bus.done, 1);
        check("b2b_result1", bus.result, 32'h00000008);
      end
      if (c == 5) begin
        check("b2b_ready5", bus.ready, 1);
        check("b2b_done5", bus.done, 0);
      end
      if (c == 6) check("b2b_ready6", bus.ready, 0);
      if (c == 9) begin
        check("b2b_done2", bus.done, 1);
        check("b2b_result2", bus.result, 32'h00000001);
      end
    end
    check("b2b_done_count", dones, 2);
    check("b2b_ready_end", bus.ready, 1);

    // kill together with valid in IDLE drops the request.
    drive(32'h12345678, 5'd4, W32, 1'b0, 1'b1, 1'b1, 1'b0);
    bus.valid = 1'b1;
    bus.kill  = 1'b1;
    tick();
    bus.valid = 1'b0;
    bus.kill  = 1'b0;
    check("kill_idle_ready", bus.ready, 1);
    check("kill_idle_done", bus.done, 0);
    tick();
    check("kill_idle_done2", bus.done, 0);

    // kill in cycle 6 of a 20-step shift.
    start_op(32'hFFFFFFFF, 5'd20, W32, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) tick();
    check("kill_run_busy", bus.ready, 0);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_ready7", bus.ready, 1);
    check("kill_done7", bus.done, 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      dones += int'(bus.done);
    end
    check("kill_no_done", dones, 0);

    // Async reset in cycle 10 of a 20-step shift.
    start_op(32'hFFFFFFFF, 5'd20, W32, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (9) tick();
    check("rst_mid_result_before", bus.result, 32'hFFFFFE00);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ready", bus.ready, 1);
    check("rst_mid_done", bus.done, 0);
    check("rst_mid_result", bus.result, 0);
    #2 reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      dones += int'(bus.done);
    end
    check("rst_mid_no_done", dones, 0);
    check("rst_mid_ready_after", bus.ready, 1);

    run_op("post_rst",   32'h12345678, 5'd4,  W32, 0, 1, 1, 0, 4,  32'h23456781);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p_shfrot_mc.md
# p_shfrot_mc

Multi-cycle, area-reduced packed shift/rotate unit with a request/response handshake. It executes the same packed shift and rotate operations as the combinational packed shifter: 32/16/8/4/2-bit lanes, shift or rotate, left or right. Each cycle it moves every lane by one bit position. It sits on the issue side of the crypto co-processor datapath, accepting operands from the instruction pipeline and handing back a held result, for low-area configurations where the full barrel shifter is too large.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  — sole clock; all state on rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `valid`  in  1  — request present; sampled only when `ready`=1.
- `kill`  in  1  — synchronous abort; highest priority after reset.
- `crs1`  in  32  — source operand.
- `shamt`  in  5  — shift/rotate amount.
- `pw`  in  5  — pack width, one-hot: [0]=32, [1]=16, [2]=8, [3]=4, [4]=2.
- `shift`, `rotate`  in  1 each  — operation class.
- `left`, `right`  in  1 each  — direction.
- `ready`  out  1  — unit idle, can accept.
- `done`  out  1  — one-cycle pulse; `result` valid.
- `result`  out  32  — operation result; held from `done` until the next accept.

## Operation
- States: IDLE, RUN, DONE. `ready`=1 only in IDLE. `done`=1 only in DONE.
- Accept: `valid`&&`ready`&&!`kill`. On accept, latch `crs1` into the data register and latch the decoded op and lane width. Load the step count k.
- Decode priority: `shift` over `rotate`, `left` over `right`.
  - If neither `shift` nor `rotate` is set, or neither `left` nor `right` is set, set k=0 and force the data register to 0.
- Width: `pw` must be exactly one-hot. Zero or multi-hot forces k=0 and data=0.
- Step count, where W is the lane width:
  - Rotate: k = `shamt` mod W, i.e. 32:`shamt[4:0]`, 16:`[3:0]`, 8:`[2:0]`, 4:`[1:0]`, 2:`[0]`.
  - Shift: k = min(`shamt`, W). Amounts ≥ W yield all-zero lanes.
- Transitions:
  - Accept with k=0: IDLE→DONE.
  - Accept with k>0: IDLE→RUN.
  - In RUN, each cycle performs one step and decrements k. The step that brings k to 0 moves RUN→DONE.
  - DONE→IDLE unconditionally after one cycle.
- One step, applied to all lanes simultaneously, with no bit crossing a lane boundary:
  - Left: lane bit i ← bit i−1. Lane LSB ← 0 (shift) or the old lane MSB (rotate).
  - Right: lane bit i ← bit i+1. Lane MSB ← 0 (shift) or the old lane LSB (rotate).
- `result` is driven from the data register. Its value is architecturally meaningful only while `done`=1 and until the next accept.
- `kill`:
  - Next state is IDLE. No `done` is produced. `result` is undefined until the next `done`.
  - `kill` together with `valid` in IDLE drops the request.
- Results must equal the combinational packed shifter bit-exactly for all legal inputs.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, `ready`=1, `done`=0, `result`=0, count=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced.
- Latency: for an accept in cycle 0, `done`=1 in cycle k+1. Worst case is 32 cycles (32-bit shift, `shamt`=31). Best case is 1 cycle.
- Throughput: one operation per k+2 cycles. `ready` is low from cycle 1 through cycle k+1 and high again in cycle k+2.
- Inputs other than `valid`/`kill` are sampled only on the accept edge. Changes during RUN have no effect.
- `done` is never asserted for two consecutive cycles.

## Test plan
- 32-bit rotate left, `shamt`=4, `crs1`=0x12345678 → `done` in cycle 5, `result`=0x23456781. `ready` low in cycles 1–5, high in cycle 6.
- 8-bit shift right, `shamt`=12, `crs1`=0xFF807F01 → k=8, `done` in cycle 9, `result`=0x00000000.
- 16-bit rotate right, `shamt`=17, `crs1`=0x00018000 → k=1, `done` in cycle 2, `result`=0x80004000.
- 2-bit shift left, `shamt`=0, `crs1`=0xDEADBEEF → `done` in cycle 1, `result`=0xDEADBEEF. A second case with `pw`=0x03 (multi-hot) → `done` in cycle 1, `result`=0.
- 4-bit rotate left, `shamt`=3, `crs1`=0x00000001, with `valid` held high back-to-back → `result`=0x00000008 in cycle 4. The second request is accepted only in cycle 5. No request is lost or duplicated.
- Abort cases, each starting a 32-bit shift left with `shamt`=20:
  - Pulse `kill` in cycle 6 → IDLE and `ready`=1 in cycle 7, no `done`.
  - Assert `reset` in cycle 10 → outputs return immediately to their reset values.
